// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle controller: FSM state encoding,
// instruction opcodes, the 7-bit ALU opcodes shared with the ALU, and the
// bit positions of the flags status word.
package cu_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK,
    HALT
  } stateT;

  // Instruction opcodes, instr[31:26]
  localparam logic [5:0] OP_OR    = 6'h00;
  localparam logic [5:0] OP_AND   = 6'h01;
  localparam logic [5:0] OP_XOR   = 6'h02;
  localparam logic [5:0] OP_ADD   = 6'h03;
  localparam logic [5:0] OP_SUB   = 6'h04;
  localparam logic [5:0] OP_SHIFT = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h10;
  localparam logic [5:0] OP_SW    = 6'h11;
  localparam logic [5:0] OP_BEQ   = 6'h18;
  localparam logic [5:0] OP_BNE   = 6'h19;
  localparam logic [5:0] OP_J     = 6'h1C;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // ALU opcodes
  localparam logic [6:0] ALU_OR    = 7'd0;
  localparam logic [6:0] ALU_AND   = 7'd1;
  localparam logic [6:0] ALU_XOR   = 7'd2;
  localparam logic [6:0] ALU_ADD   = 7'd3;
  localparam logic [6:0] ALU_SUB   = 7'd4;
  localparam logic [6:0] ALU_SHIFT = 7'd5;

  // Bit indices within the flags word {par,ovf,cout,neg,zero}
  localparam int unsigned FLAG_ZERO = 0;
  localparam int unsigned FLAG_NEG  = 1;
  localparam int unsigned FLAG_COUT = 2;
  localparam int unsigned FLAG_OVF  = 3;
  localparam int unsigned FLAG_PAR  = 4;

  function automatic logic [31:0] signExtend16(input logic [15:0] value);
    return {{16{value[15]}}, value};
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundle of all controller-facing signals except clock and reset.
//   master : control unit side (drives PC, strobes, ALU controls, status)
//   slave  : environment side (instruction/data memory acks, ALU flags)
interface control_unit_if;
  logic [31:0] instr;
  logic        imem_ack;
  logic        dmem_ack;
  logic        alu_zero;
  logic        alu_neg;
  logic        alu_cout;
  logic        alu_ovf;
  logic        alu_par;
  logic [31:0] pc;
  logic        imem_req;
  logic [6:0]  alu_op;
  logic        use_imm;
  logic [31:0] imm;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic        reg_we;
  logic        wb_sel_mem;
  logic        dmem_re;
  logic        dmem_we;
  logic [4:0]  flags;
  logic        halted;
  logic        illegal;

  modport master (
    input  instr, imem_ack, dmem_ack, alu_zero, alu_neg, alu_cout, alu_ovf, alu_par,
    output pc, imem_req, alu_op, use_imm, imm, rs_addr, rt_addr, rd_addr,
           reg_we, wb_sel_mem, dmem_re, dmem_we, flags, halted, illegal
  );

  modport slave (
    output instr, imem_ack, dmem_ack, alu_zero, alu_neg, alu_cout, alu_ovf, alu_par,
    input  pc, imem_req, alu_op, use_imm, imm, rs_addr, rt_addr, rd_addr,
           reg_we, wb_sel_mem, dmem_re, dmem_we, flags, halted, illegal
  );
endinterface

// File: rtl/cu_decoder.sv
// Combinational instruction decoder: opcode field of the latched IR ->
// ALU opcode, operand select and instruction class bits.
//   opcode    in  6  IR[31:26]
//   aluOp     out 7  ALU opcode used during EXECUTE
//   useImm    out 1  B operand is the sign-extended immediate
//   isLoad/isStore/isBranch/branchNe/isJump/writesRd  class bits
//   illegal   out 1  opcode is not defined
module cu_decoder
  import cu_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [6:0] aluOp,
  output logic       useImm,
  output logic       isLoad,
  output logic       isStore,
  output logic       isBranch,
  output logic       branchNe,
  output logic       isJump,
  output logic       writesRd,
  output logic       illegal
);

  always_comb begin
    aluOp    = ALU_OR;
    useImm   = 1'b0;
    isLoad   = 1'b0;
    isStore  = 1'b0;
    isBranch = 1'b0;
    branchNe = 1'b0;
    isJump   = 1'b0;
    writesRd = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_OR, OP_AND, OP_XOR, OP_ADD, OP_SUB, OP_SHIFT: begin
        aluOp    = 7'(opcode);
        writesRd = 1'b1;
      end
      OP_ADDI: begin
        aluOp    = ALU_ADD;
        useImm   = 1'b1;
        writesRd = 1'b1;
      end
      OP_LW: begin
        aluOp    = ALU_ADD;
        useImm   = 1'b1;
        isLoad   = 1'b1;
        writesRd = 1'b1;
      end
      OP_SW: begin
        aluOp   = ALU_ADD;
        useImm  = 1'b1;
        isStore = 1'b1;
      end
      OP_BEQ: begin
        aluOp    = ALU_SUB;
        isBranch = 1'b1;
      end
      OP_BNE: begin
        aluOp    = ALU_SUB;
        isBranch = 1'b1;
        branchNe = 1'b1;
      end
      OP_J:    isJump = 1'b1;
      OP_HALT: ;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle controller upstream of the ALU. Owns the PC and instruction
// register, sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, and latches ALU
// flags at the end of EXECUTE into a status word.
//   clk, rst : clock and synchronous active-high reset
//   bus      : control_unit_if.master (memory handshakes, ALU controls,
//              register-file addresses/strobes, PC and status)
// Every output is a register or a decode of state + IR; acks only steer
// the next state.
module control_unit
  import cu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic clk,
  input  logic rst,
  control_unit_if.master bus
);

  stateT       state, nextState;
  logic [31:0] pc, pcNext, ir;
  logic [4:0]  flags;
  logic        illegalQ;

  logic [6:0]  decAluOp;
  logic        decUseImm, decIsLoad, decIsStore, decIsBranch, decBranchNe;
  logic        decIsJump, decWritesRd, decIllegal;

  logic [31:0] imm, pcInc, pcTarget;
  logic        branchTaken;

  cu_decoder uDecoder (
    .opcode   (ir[31:26]),
    .aluOp    (decAluOp),
    .useImm   (decUseImm),
    .isLoad   (decIsLoad),
    .isStore  (decIsStore),
    .isBranch (decIsBranch),
    .branchNe (decBranchNe),
    .isJump   (decIsJump),
    .writesRd (decWritesRd),
    .illegal  (decIllegal)
  );

  assign imm      = signExtend16(ir[15:0]);
  assign pcInc    = pc + 32'(PC_STEP);
  // imm<<2 keeps only the low 32 bits; all PC sums wrap mod 2^32
  assign pcTarget = pcInc + {imm[29:0], 2'b00};
  assign branchTaken = decBranchNe ? ~bus.alu_zero : bus.alu_zero;

  always_comb begin
    nextState = state;
    pcNext    = pc;
    case (state)
      FETCH: if (bus.imem_ack) nextState = DECODE;
      DECODE: begin
        if (ir[31:26] == OP_HALT || decIllegal) begin
          nextState = HALT;
        end else if (decIsJump) begin
          nextState = FETCH;
          pcNext    = pcTarget;
        end else begin
          nextState = EXECUTE;
        end
      end
      EXECUTE: begin
        if (decIsBranch) begin
          nextState = FETCH;
          pcNext    = branchTaken ? pcTarget : pcInc;
        end else if (decIsLoad || decIsStore) begin
          nextState = MEMORY;
        end else begin
          nextState = WRITEBACK;
        end
      end
      MEMORY: begin
        if (bus.dmem_ack) begin
          if (decIsStore) begin
            nextState = FETCH;
            pcNext    = pcInc;
          end else begin
            nextState = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        nextState = FETCH;
        pcNext    = pcInc;
      end
      HALT:    nextState = HALT;
      default: nextState = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      flags    <= '0;
      illegalQ <= 1'b0;
    end else begin
      state <= nextState;
      pc    <= pcNext;
      if (state == FETCH && bus.imem_ack) ir <= bus.instr;
      if (state == EXECUTE) begin
        flags[FLAG_ZERO] <= bus.alu_zero;
        flags[FLAG_NEG]  <= bus.alu_neg;
        flags[FLAG_COUT] <= bus.alu_cout;
        flags[FLAG_OVF]  <= bus.alu_ovf;
        flags[FLAG_PAR]  <= bus.alu_par;
      end
      if (state == DECODE && decIllegal) illegalQ <= 1'b1;
    end
  end

  assign bus.pc         = pc;
  assign bus.imem_req   = (state == FETCH);
  assign bus.alu_op     = (state == EXECUTE) ? decAluOp : ALU_OR;
  assign bus.use_imm    = (state == EXECUTE) && decUseImm;
  assign bus.imm        = imm;
  assign bus.rs_addr    = ir[20:16];
  assign bus.rt_addr    = ir[15:11];
  assign bus.rd_addr    = ir[25:21];
  assign bus.reg_we     = (state == WRITEBACK) && decWritesRd;
  assign bus.wb_sel_mem = (state == WRITEBACK) && decIsLoad;
  assign bus.dmem_re    = (state == MEMORY) && decIsLoad;
  assign bus.dmem_we    = (state == MEMORY) && decIsStore;
  assign bus.flags      = flags;
  assign bus.halted     = (state == HALT);
  assign bus.illegal    = illegalQ;

endmodule
